// File: rtl/if_pkg.sv
// if_pkg: shared types and constants for the instruction-fetch stage.
package if_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} fetch_state_e;
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: instruction-memory, redirect and decode-side signals of the fetch stage.
interface if_stage_if;
  import if_pkg::*;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_instruction;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] fetch_count;
  modport master (
    input  redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, id_ready,
    output imem_req, imem_addr, id_valid, id_instruction, id_pc, fetch_count
  );
  modport slave (
    output redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, id_ready,
    input  imem_req, imem_addr, id_valid, id_instruction, id_pc, fetch_count
  );
endinterface

// File: rtl/if_fifo.sv
// if_fifo: synchronous FIFO with flush; used for the instruction buffer and the PC queue.
module if_fifo import if_pkg::*; #(
  parameter int  DEPTH = 4,
  parameter type T     = fetch_entry_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  T                           i_data,
  output T                           o_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_empty,
  output logic                       o_full
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  T              r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  function automatic logic [AW-1:0] inc(logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + AW'(1);
  endfunction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wp <= inc(r_wp);
      if (i_pop) r_rp <= inc(r_rp);
      r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wp] <= i_data;
  end
  assign o_data  = r_mem[r_rp];
  assign o_count = r_cnt;
  assign o_empty = r_cnt == '0;
  assign o_full  = r_cnt == CW'(DEPTH);
endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch with credit-limited imem requests, response buffer and redirect flush.
// Define IF_PERF_CNT_EN to build the retired-fetch counter on fetch_count.
module if_stage import if_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC        = 32'h0000_0000,
  parameter int              FIFO_DEPTH      = 4,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic      clk,
  input  logic      rst,
  if_stage_if.master bus
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  fetch_state_e    r_state;
  logic [XLEN-1:0] r_fetch_pc;
  logic [OW-1:0]   r_out, r_discard, w_out_rem, w_discard_nxt, w_pcq_cnt;
  logic [CW-1:0]   w_cnt;
  logic            w_req, w_fire, w_rv, w_drop, w_push, w_pop;
  logic            w_empty, w_full, w_pcq_empty, w_pcq_full;
  logic [XLEN-1:0] w_pcq_pc;
  fetch_entry_t    w_entry, w_head;
  // Responses arriving with nothing outstanding (e.g. straggling across a reset) are ignored.
  assign w_rv          = bus.imem_rvalid && r_out != '0;
  assign w_drop        = w_rv && r_discard != '0;
  assign w_push        = w_rv && !w_drop && !bus.redirect_valid;
  assign w_pop         = bus.id_valid && bus.id_ready;
  assign w_out_rem     = r_out - OW'(w_rv);
  assign w_discard_nxt = bus.redirect_valid ? w_out_rem : r_discard - OW'(w_drop);
  assign w_req         = r_state != IDLE && !bus.redirect_valid && r_out < OW'(MAX_OUTSTANDING) &&
                         32'(w_cnt) + 32'(r_out) - 32'(w_pop) < 32'(FIFO_DEPTH);
  assign w_fire        = w_req && bus.imem_gnt;
  assign w_entry       = '{instr: bus.imem_rdata, pc: w_pcq_pc};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_out      <= '0;
      r_discard  <= '0;
    end else begin
      r_out      <= w_out_rem + OW'(w_fire);
      r_discard  <= w_discard_nxt;
      r_fetch_pc <= bus.redirect_valid ? bus.redirect_pc & ~32'h3 : w_fire ? r_fetch_pc + 32'd4 : r_fetch_pc;
      r_state    <= r_state == IDLE ? RUN :
                    bus.redirect_valid ? (w_out_rem != '0 ? FLUSH : RUN) :
                    (r_state == FLUSH && w_discard_nxt == '0) ? RUN : r_state;
    end
  end
  if_fifo #(.DEPTH(FIFO_DEPTH), .T(fetch_entry_t)) u_ibuf (
    .clk(clk), .rst(rst), .i_push(w_push), .i_pop(w_pop), .i_flush(bus.redirect_valid),
    .i_data(w_entry), .o_data(w_head), .o_count(w_cnt), .o_empty(w_empty), .o_full(w_full)
  );
  // Holds only addresses whose responses will be kept; discarded ones were flushed on redirect.
  if_fifo #(.DEPTH(MAX_OUTSTANDING), .T(logic [XLEN-1:0])) u_pcq (
    .clk(clk), .rst(rst), .i_push(w_fire), .i_pop(w_rv && !w_drop), .i_flush(bus.redirect_valid),
    .i_data(r_fetch_pc), .o_data(w_pcq_pc), .o_count(w_pcq_cnt), .o_empty(w_pcq_empty), .o_full(w_pcq_full)
  );
  assign bus.imem_req       = w_req;
  assign bus.imem_addr      = r_fetch_pc;
  assign bus.id_valid       = !w_empty && !bus.redirect_valid;
  assign bus.id_instruction = w_empty ? NOP_INSTR : w_head.instr;
  assign bus.id_pc          = w_empty ? '0 : w_head.pc;
`ifdef IF_PERF_CNT_EN
  logic [XLEN-1:0] r_fetch_count;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_fetch_count <= '0;
    else if (w_pop) r_fetch_count <= r_fetch_count + 32'd1;
  end
  assign bus.fetch_count = r_fetch_count;
`else
  assign bus.fetch_count = '0;
`endif
  a_late_rvalid: assert property (@(posedge clk) disable iff (rst) bus.imem_rvalid |-> r_out != '0);
  a_pcq_sane: assert property (@(posedge clk) disable iff (rst)
    !(w_fire && w_pcq_full) && !(w_push && w_pcq_empty) && w_pcq_cnt <= r_out);
  a_ibuf_overflow: assert property (@(posedge clk) disable iff (rst) !(w_push && w_full && !w_pop));
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: scoreboard bench for if_stage with a 1-cycle in-order memory model.
module tb_if_stage;
  import if_pkg::*;
  logic clk = 0;
  logic rst = 1;
  int   n_cmp = 0, n_err = 0;
  logic [31:0] mem_q[$];
  logic [31:0] sb[$];
  logic [31:0] exp_fa = 32'h0;
  int   takes = 0, stalls = 0, gnt_hold = 0;
  logic gnt_en = 1, rv_en = 1, last_req = 0, last_idv = 0;
  if_stage_if bus();
  if_stage dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [31:0] instr_of(logic [31:0] a);
    return {a[31:2], 2'b11} ^ 32'h5A5A_0000;
  endfunction
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic chk_reset_outputs();
    chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_idv", {31'b0, bus.id_valid}, 32'd0);
    chk("rst_instr", bus.id_instruction, NOP_INSTR);
    chk("rst_pc", bus.id_pc, 32'h0);
    chk("rst_fcnt", bus.fetch_count, 32'h0);
  endtask
  task automatic chk_fcnt();
`ifdef IF_PERF_CNT_EN
    chk("fetch_count", bus.fetch_count, 32'(takes));
`else
    chk("fetch_count", bus.fetch_count, 32'h0);
`endif
  endtask
  task automatic cycle();
    logic fire, take, rv, redir;
    logic [31:0] addr, rpc, e;
    @(negedge clk);
    bus.imem_rvalid = mem_q.size() > 0 && rv_en;
    bus.imem_rdata  = bus.imem_rvalid ? instr_of(mem_q[0]) : 32'h0;
    bus.imem_gnt    = gnt_en;
    if (gnt_hold > 0 && bus.imem_req && exp_fa == 32'h8) begin
      bus.imem_gnt = 0;
      gnt_hold--;
      stalls++;
    end
    #1;
    if (bus.imem_req) chk("fetch_addr", bus.imem_addr, exp_fa);
    last_req = bus.imem_req;
    last_idv = bus.id_valid;
    addr  = bus.imem_addr;
    fire  = bus.imem_req && bus.imem_gnt;
    take  = bus.id_valid && bus.id_ready;
    rv    = bus.imem_rvalid;
    redir = bus.redirect_valid;
    rpc   = bus.redirect_pc;
    if (redir) begin
      chk("redir_idv", {31'b0, bus.id_valid}, 32'd0);
      chk("redir_req", {31'b0, bus.imem_req}, 32'd0);
    end
    if (take) begin
      if (sb.size() == 0) chk("take_unexpected", {31'b0, take}, 32'd0);
      else begin
        e = sb.pop_front();
        chk("id_pc", bus.id_pc, e);
        chk("id_instr", bus.id_instruction, instr_of(e));
      end
      takes++;
    end
    @(posedge clk);
    #1;
    if (rv) void'(mem_q.pop_front());
    if (redir) begin
      sb.delete();
      exp_fa = rpc & ~32'h3;
    end
    if (fire) begin
      mem_q.push_back(addr);
      sb.push_back(addr);
      exp_fa += 4;
    end
    bus.redirect_valid = 0;
  endtask
  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask
  task automatic drain();
    for (int i = 0; i < 40 && sb.size() > 0; i++) cycle();
    chk("drain", 32'(sb.size()), 32'd0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int t0;
    bus.redirect_valid = 0;
    bus.redirect_pc    = 0;
    bus.imem_gnt       = 0;
    bus.imem_rvalid    = 0;
    bus.imem_rdata     = 0;
    bus.id_ready       = 1;
    #2;
    chk_reset_outputs();
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    chk("idle_req", {31'b0, bus.imem_req}, 32'd0);
    cycle();
    chk("first_req", {31'b0, last_req}, 32'd1);
    run(7);
    t0 = takes;
    run(10);
    chk("throughput", 32'(takes - t0), 32'd10);
    // decode stall: buffer plus in-flight must cap at FIFO_DEPTH
    bus.id_ready = 0;
    run(10);
    chk("bp_buffered", 32'(sb.size()), 32'd4);
    chk("bp_req", {31'b0, last_req}, 32'd0);
    chk("bp_idv", {31'b0, last_idv}, 32'd1);
    bus.id_ready = 1;
    run(10);
    // hold responses until two fetches are in flight, then redirect
    rv_en = 0;
    for (int i = 0; i < 20 && mem_q.size() < 2; i++) cycle();
    chk("two_outstanding", 32'(mem_q.size()), 32'd2);
    bus.redirect_valid = 1;
    bus.redirect_pc    = 32'h103;
    cycle();
    rv_en = 1;
    run(12);
    chk("after_flush_fa", exp_fa, bus.imem_addr);
    // redirect coinciding with rvalid and a decode handshake
    bus.redirect_valid = 1;
    bus.redirect_pc    = 32'h200;
    cycle();
    run(10);
    chk_fcnt();
    // asynchronous reset in the middle of the stream
    @(negedge clk);
    #2;
    rst = 1;
    #1;
    chk_reset_outputs();
    mem_q.delete();
    sb.delete();
    exp_fa = 32'h0;
    takes  = 0;
    bus.imem_rvalid = 0;
    bus.imem_gnt    = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    chk("idle_req2", {31'b0, bus.imem_req}, 32'd0);
    gnt_hold = 3;
    stalls   = 0;
    run(20);
    chk("gnt_stalls", 32'(stalls), 32'd3);
    gnt_en = 0;
    drain();
    chk_fcnt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
